// File: rtl/reg_piso_unloader_if.sv
// reg_piso_unloader_if: parallel-load handshake plus serial sink strobes for the unloader
interface reg_piso_unloader_if #(
   parameter int N = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_data;
   logic         ser_stall;
   logic         ser_out;
   logic         ser_valid;
   logic         ser_last;
   logic         busy;

   modport master (
      output in_valid, in_data, ser_stall,
      input  in_ready, ser_out, ser_valid, ser_last, busy
   );

   modport slave (
      input  in_valid, in_data, ser_stall,
      output in_ready, ser_out, ser_valid, ser_last, busy
   );
endinterface

// File: rtl/reg_piso_unloader.sv
// reg_piso_unloader: accepts an N-bit word and shifts it out one bit per cycle with valid/last strobes
module reg_piso_unloader #(
   parameter int N         = 32,
   parameter bit MSB_FIRST = 1'b0
) (
   input logic                clk,
   input logic                rst,
   reg_piso_unloader_if.slave bus
);
   localparam int CW = $clog2(N);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          state;
   state_t          state_nx;
   logic [N-1:0]    sreg;
   logic [CW-1:0]   cnt;
   logic            ser_out;
   logic            ser_valid;
   logic            ser_last;
   logic            busy;
   logic            in_ready;
   logic            take;
   logic            adv;
   logic            last_out;

   // state register; reset is asynchronous and active-low
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else      state <= state_nx;

   // a new word can only start from IDLE or as the final bit leaves
   always_comb
      state_nx = (state == IDLE || last_out) ? (bus.in_valid ? SHIFT : IDLE) : state;

   // handshake and shift enables; the final bit leaving frees the slot in the same cycle
   always_comb begin
      last_out = (state == SHIFT) && (cnt == '0) && !bus.ser_stall;
      in_ready = (state == IDLE) || last_out;
      take     = bus.in_valid && in_ready;
      adv      = (state == SHIFT) && !bus.ser_stall;
   end

   // datapath: load presents the first bit at once, so sreg only holds the bits still to come
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         sreg      <= '0;
         cnt       <= '0;
         ser_out   <= 1'b0;
         ser_valid <= 1'b0;
         ser_last  <= 1'b0;
         busy      <= 1'b0;
      end else if (take) begin
         ser_out   <= MSB_FIRST ? bus.in_data[N-1] : bus.in_data[0];
         sreg      <= MSB_FIRST ? bus.in_data << 1 : bus.in_data >> 1;
         cnt       <= CW'(N-1);
         ser_valid <= 1'b1;
         ser_last  <= 1'b0;
         busy      <= 1'b1;
      end else if (last_out) begin
         sreg      <= '0;
         cnt       <= '0;
         ser_out   <= 1'b0;
         ser_valid <= 1'b0;
         ser_last  <= 1'b0;
         busy      <= 1'b0;
      end else if (adv) begin
         ser_out   <= MSB_FIRST ? sreg[N-1] : sreg[0];
         sreg      <= MSB_FIRST ? sreg << 1 : sreg >> 1;
         cnt       <= cnt - CW'(1);
         ser_last  <= (cnt == CW'(1));
      end

   assign bus.in_ready  = in_ready;
   assign bus.ser_out   = ser_out;
   assign bus.ser_valid = ser_valid;
   assign bus.ser_last  = ser_last;
   assign bus.busy      = busy;
endmodule

// File: doc/reg_piso_unloader.md
Name: reg_piso_unloader

Overview:
- Reader-side counterpart to the processor's parallel-load N-bit register.
- Accepts an N-bit word over a valid/ready handshake, holds it internally, and shifts it out one bit per cycle with valid/last strobes.
- Serves serial trace/debug readout of processor registers (PC, instruction, writeback data) to an off-core serial sink.
- The downstream sink can pause the shift; back-to-back words stream with no bubble.

Parameters:
- N, 32, word width in bits; N >= 2.
- MSB_FIRST, 0, 0 = bit 0 shifted out first; 1 = bit N-1 shifted out first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 forces the reset state immediately, independent of clk.
- in_valid  input  1  in_data holds a word to unload.
- in_ready  output  1  block accepts in_data this cycle. Transfer occurs when in_valid & in_ready at a rising edge.
- in_data  input  N  parallel word.
- ser_stall  input  1  sink not ready; freezes the shift.
- ser_out  output  1  current serial bit (registered).
- ser_valid  output  1  ser_out is a live data bit (registered).
- ser_last  output  1  ser_out is the final bit of the word (registered).
- busy  output  1  a word is held and not yet fully shifted out.

Behaviour:
- State machine has two states:
  - IDLE: no word held.
  - SHIFT: word held in the shift register; bit counter cnt, width clog2(N), counts bits remaining minus one.
- Reset (rst=0, asynchronous):
  - State goes to IDLE; shift register, cnt, ser_out, ser_valid, ser_last and busy all clear to 0.
  - in_ready is 1 while in reset, because in_ready is derived from the IDLE state.
- in_ready is combinational: 1 in IDLE; also 1 in SHIFT when cnt==0 and ser_stall==0 (last bit leaving this cycle); otherwise 0.
- Acceptance (IDLE, in_valid=1 at edge k):
  - Word is captured.
  - At edge k, ser_out is driven with the first bit (bit 0, or bit N-1 if MSB_FIRST=1); ser_valid=1, busy=1, cnt=N-1.
  - Latency: the first bit is visible in the cycle after the handshake.
- Shifting (SHIFT, ser_stall=0 at edge):
  - The next bit is presented and cnt decrements.
  - ser_last=1 exactly while the final bit is presented (cnt==0).
  - Each data bit is presented for exactly one non-stalled cycle.
- Stall (ser_stall=1 at edge):
  - ser_out, ser_valid, ser_last, cnt and the shift register all hold.
  - in_ready=0 in SHIFT regardless of cnt.
- End of word (cnt==0, ser_stall=0 at edge):
  - If in_valid=1, the new word is captured and its first bit presented at that same edge. ser_valid stays 1 (no bubble), ser_last falls to 0, cnt reloads to N-1.
  - Otherwise the state goes to IDLE; ser_valid, ser_last and busy fall to 0, and ser_out goes to 0.
- in_valid while in SHIFT with in_ready=0 is ignored; the source must hold the word.
- in_data is sampled only on the transfer edge; later changes have no effect.
- Reset mid-word discards the remaining bits; no partial word is emitted after rst rises.
- First rising edge after reset release with in_valid=1 is a normal acceptance.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, with pulses asserted between clock edges -> ser_valid=ser_last=busy=ser_out=0 immediately, in_ready=1; release with in_valid=0 -> outputs stay 0 for 10 cycles.
- Single LSB-first word:
  - Stimulus: N=32, MSB_FIRST=0, send 0x8000_0001 at edge 0.
  - Required: edges 1..32 show ser_out = 1, then 0 x30, then 1; ser_valid=1 across edges 1..32; ser_last=1 only at edge 32; IDLE at edge 33.
- MSB-first, N=8, send 0xA5 -> serial sequence 1,0,1,0,0,1,0,1; ser_last on the 8th bit.
- Back-to-back:
  - Stimulus: N=8, send 0x0F, then hold in_valid=1 with 0xF0.
  - Required: in_ready pulses 1 only on the last-bit cycle; 16 consecutive valid bits 1111_0000_0000_1111 (LSB-first per word, no bubble).
- Stall: N=8, send 0x3C, assert ser_stall for 4 cycles after the 3rd bit -> bit 3 (value 1) held for 5 cycles, in_ready=0 throughout, final sequence unchanged, ser_last on the 8th distinct bit.
- Reset mid-word: N=32, send 0xFFFF_FFFF, assert rst=0 asynchronously after 10 bits -> ser_valid drops without a clock edge; after release, in_ready=1 and no further bits appear.
